raizing_rom_arbiter: RTL and testbench
======================================

# raizing_rom_arbiter

Parametrised N-channel SDRAM read arbiter with per-channel single-entry caches. It replaces the fixed per-game slot wiring between ROM clients (68K program, Z80 program, PCM, GFX/scroll fetchers) and one SDRAM bank port. It accepts CS/ADDR requests from CHANNELS clients and serialises misses onto the bank handshake. Each client gets its data plus an OK flag that is valid while its address matches the cached word.

## Interface
- CHANNELS, 4: number of client channels (1..8).
- AW, 22: SDRAM word-address width.
- CAW, 20: client address width (units of DW).
- DW, 32: client data width, 16 or 32; 32 = two SDRAM beats, low half first.
- RR, 1: 1 = round-robin arbitration; 0 = fixed priority, channel 0 highest.
- CH_OFFSET, 0: packed CHANNELS*AW vector of per-channel SDRAM word offsets.

Ports:
- CLK  in  1  system clock (96 MHz domain).
- RESET_N  in  1  asynchronous, active-low reset.
- INVALIDATE  in  1  clears all cache entries (tie to downloading).
- CH_CS  in  CHANNELS  per-channel read request.
- CH_ADDR  in  CHANNELS*CAW  packed client addresses.
- CH_OK  out  CHANNELS  CH_DOUT valid for current CH_ADDR.
- CH_DOUT  out  CHANNELS*DW  packed cached data.
- BA_ADDR  out  AW  SDRAM word address.
- BA_RD  out  1  read request.
- BA_ACK  in  1  request accepted (one-cycle pulse).
- BA_DOK  in  1  DATA_READ valid this cycle.
- BA_RDY  in  1  final beat of the burst (coincides with its DOK).
- DATA_READ  in  16  SDRAM read data.

## Operation
- Per channel: tag register (CAW), valid bit, data register (DW).
- CH_OK[i] = CH_CS[i] & valid[i] & (CH_ADDR[i] == tag[i]). Combinational from registered state.
- CH_DOUT[i] = data[i]. Unconditional, so the output holds across CS drop.
- Miss[i] = CH_CS[i] & ~CH_OK[i].
- FSM states: IDLE, REQ, DATA.
- IDLE: if any miss, select a winner and latch its index and CH_ADDR into sel/lat_addr. Drive BA_ADDR = CH_OFFSET[sel] + lat_addr*(DW/16), truncated to AW. Go to REQ.
  - RR=1: search starts at (last_winner+1) mod CHANNELS.
  - RR=0: lowest index wins.
- REQ: BA_RD=1, BA_ADDR held. On BA_ACK: BA_RD=0 the next cycle, beat counter=0, go to DATA.
- DATA: on each BA_DOK, store DATA_READ into beat[cnt] and increment cnt.
  - BA_DOK with BA_RDY: write tag[sel]=lat_addr, data[sel]=assembled word {beat1,beat0} or beat0, valid[sel]=1; go to IDLE.
  - BA_RDY arriving before DW/16 beats: missing beats are zero.
  - Beats beyond DW/16: ignored.
- Client changes ADDR or drops CS mid-fetch: the fetch completes and is cached under lat_addr. CH_OK reflects the tag compare only.
- INVALIDATE high: all valid bits clear that cycle and stay clear while high.
  - A fetch in flight completes the handshake, but its result is not marked valid if INVALIDATE was seen at any point during it.
  - FSM does not start new fetches while INVALIDATE is high.
- Completion and a new miss in the same cycle: the new arbitration happens in the following IDLE cycle.

## Timing
- Reset values: BA_RD=0, BA_ADDR=0, CH_OK=0, CH_DOUT=0, all valid=0, state IDLE, last_winner=CHANNELS-1.
- Hit latency: 0 cycles (OK is combinational).
- Miss latency, no contention: IDLE→REQ 1 cycle; BA_RD asserted from cycle 1 until ACK; CH_OK rises the cycle after the BA_RDY beat.
- BA_RD must stay high until BA_ACK; never re-asserted in the cycle after ACK.
- One outstanding request at a time.
- RESET_N low mid-fetch: immediate abort, BA_RD=0. The SDRAM controller shares this reset.

## Test plan
- Single hit/miss: CH_CS[0]=1, ADDR=0x00010, DW=32, offset 0. BA_ADDR=0x20, beats 0x1234 then 0x5678 (RDY) → CH_DOUT[0]=0x56781234, CH_OK[0]=1 the next cycle. Re-request of the same address gives OK=1 with no BA_RD.
- Round-robin: channels 0..3 all missing simultaneously, RR=1 → BA_RD issued for 0,1,2,3 in order. Repeated misses on 0 and 1 alternate 0,1,0,1. With RR=0, channel 0 starves channel 1.
- Offset: CH_OFFSET[2]=0x100000, ADDR=5 → BA_ADDR=0x10000A.
- Address change mid-fetch: channel 1 requests 0x40, then switches to 0x41 after ACK → tag=0x40, OK stays 0, then a second fetch for 0x41 follows.
- INVALIDATE during DATA: result not marked valid; all OK=0; no new BA_RD until INVALIDATE falls; the refetch then occurs.
- Reset mid-REQ: RESET_N low while BA_RD=1 → BA_RD=0 asynchronously, all OK=0. After release, the pending miss is re-requested.

Source files
------------

// File: rtl/raizing_rom_arbiter_if.sv
// SDRAM bank read port shared between the ROM arbiter and the SDRAM controller.
// Latency: n/a (wires only).
// Backpressure: BA_RD is held until BA_ACK; data returns on BA_DOK, burst ends on BA_RDY.
//
// Signals:
//   BA_ADDR   SDRAM word address            (arbiter -> controller)
//   BA_RD     read request, held until ACK  (arbiter -> controller)
//   BA_ACK    request accepted, 1-cycle     (controller -> arbiter)
//   BA_DOK    DATA_READ valid this cycle    (controller -> arbiter)
//   BA_RDY    last beat of the burst        (controller -> arbiter)
//   DATA_READ 16-bit read data              (controller -> arbiter)
interface raizing_rom_arbiter_if #(
    parameter int AW = 22
);
    logic [AW-1:0] BA_ADDR;
    logic          BA_RD;
    logic          BA_ACK;
    logic          BA_DOK;
    logic          BA_RDY;
    logic [15:0]   DATA_READ;

    modport master (
        output BA_ADDR, BA_RD,
        input  BA_ACK, BA_DOK, BA_RDY, DATA_READ
    );

    modport slave (
        input  BA_ADDR, BA_RD,
        output BA_ACK, BA_DOK, BA_RDY, DATA_READ
    );
endinterface

// File: rtl/raizing_rom_arbiter.sv
// N-channel SDRAM read arbiter with one cached word per client channel.
// Latency: hits 0 cycles; misses go IDLE->REQ in 1 cycle, CH_OK rises the cycle after the BA_RDY beat.
// Backpressure: one outstanding fetch; BA_RD held until BA_ACK; no new fetch while INVALIDATE is high.
//
// Ports:
//   CLK, RESET_N       clock, asynchronous active-low reset (shared with the SDRAM controller)
//   INVALIDATE         drops every cached entry while high
//   CH_CS / CH_ADDR    per-channel read request and packed CAW-bit word addresses
//   CH_OK / CH_DOUT    per-channel hit flag and packed cached data (DOUT held across CS drop)
//   ba                 SDRAM bank read port (master side)
module raizing_rom_arbiter #(
    parameter int                         CHANNELS  = 4,
    parameter int                         AW        = 22,
    parameter int                         CAW       = 20,
    parameter int                         DW        = 32,
    parameter int                         RR        = 1,
    parameter logic [CHANNELS*AW-1:0]     CH_OFFSET = '0
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      INVALIDATE,
    input  logic [CHANNELS-1:0]       CH_CS,
    input  logic [CHANNELS*CAW-1:0]   CH_ADDR,
    output logic [CHANNELS-1:0]       CH_OK,
    output logic [CHANNELS*DW-1:0]    CH_DOUT,
    raizing_rom_arbiter_if.master     ba
);

    localparam int IW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BEATS = DW / 16;
    // A 32-bit client word spans two SDRAM words, so client addresses are doubled.
    localparam int SH    = (DW == 32) ? 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA
    } state_t;

    state_t                          state_q, state_d;
    logic [IW-1:0]                   sel_q, sel_d;
    logic [IW-1:0]                   last_q, last_d;
    logic [CAW-1:0]                  lat_addr_q, lat_addr_d;
    logic [AW-1:0]                   ba_addr_q, ba_addr_d;
    logic                            ba_rd_q, ba_rd_d;
    logic [1:0]                      cnt_q, cnt_d;
    logic [15:0]                     beat0_q, beat0_d;
    logic [15:0]                     beat1_q, beat1_d;
    logic                            inv_seen_q, inv_seen_d;
    logic [CHANNELS-1:0]             valid_q, valid_d;
    logic [CHANNELS-1:0][CAW-1:0]    tag_q, tag_d;
    logic [CHANNELS-1:0][DW-1:0]     data_q, data_d;

    logic [CHANNELS-1:0]             hit;
    logic [CHANNELS-1:0]             miss;
    logic                            win_found;
    logic [IW-1:0]                   win_idx;
    logic [CAW-1:0]                  win_addr;
    logic [AW-1:0]                   win_off;
    logic [AW+CAW-1:0]               win_scaled;
    logic                            wr_beat;
    logic [15:0]                     b0, b1;
    logic [31:0]                     word;

    // Hit detection is purely a tag compare; it does not care what the FSM is doing.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            hit[i] = CH_CS[i] & valid_q[i] & (CH_ADDR[i*CAW +: CAW] == tag_q[i]);
        end
    end

    assign miss        = CH_CS & ~hit;
    assign CH_OK       = hit;
    assign CH_DOUT     = data_q;
    assign ba.BA_ADDR  = ba_addr_q;
    assign ba.BA_RD    = ba_rd_q;

    // Winner search: rotating start after the last winner, or fixed from channel 0.
    always_comb begin
        int cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand = (RR != 0) ? ((int'(last_q) + 1 + k) % CHANNELS) : k;
            if (!win_found && miss[cand]) begin
                win_found = 1'b1;
                win_idx   = IW'(cand);
            end
        end
        win_addr   = CH_ADDR[int'(win_idx)*CAW +: CAW];
        win_off    = CH_OFFSET[int'(win_idx)*AW +: AW];
        win_scaled = {{AW{1'b0}}, win_addr} << SH;
    end

    // Beat capture; beats past the client width are dropped and unreceived beats stay zero
    // because the beat registers are cleared when the request is accepted.
    always_comb begin
        wr_beat = ba.BA_DOK && (int'(cnt_q) < BEATS);
        b0      = (wr_beat && cnt_q == 2'd0) ? ba.DATA_READ : beat0_q;
        b1      = (wr_beat && cnt_q == 2'd1) ? ba.DATA_READ : beat1_q;
        word    = {b1, b0};
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        lat_addr_d = lat_addr_q;
        ba_addr_d  = ba_addr_q;
        ba_rd_d    = ba_rd_q;
        cnt_d      = cnt_q;
        beat0_d    = beat0_q;
        beat1_d    = beat1_q;
        inv_seen_d = inv_seen_q;
        tag_d      = tag_q;
        data_d     = data_q;
        valid_d    = INVALIDATE ? '0 : valid_q;

        case (state_q)
            ST_IDLE: begin
                if (win_found && !INVALIDATE) begin
                    sel_d      = win_idx;
                    last_d     = win_idx;
                    lat_addr_d = win_addr;
                    ba_addr_d  = win_off + win_scaled[AW-1:0];
                    ba_rd_d    = 1'b1;
                    inv_seen_d = 1'b0;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (INVALIDATE) inv_seen_d = 1'b1;
                if (ba.BA_ACK) begin
                    ba_rd_d = 1'b0;
                    cnt_d   = 2'd0;
                    beat0_d = 16'h0000;
                    beat1_d = 16'h0000;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (INVALIDATE) inv_seen_d = 1'b1;
                if (ba.BA_DOK) begin
                    beat0_d = b0;
                    beat1_d = b1;
                    if (cnt_q < 2'd2) cnt_d = cnt_q + 2'd1;
                    if (ba.BA_RDY) begin
                        // Cached under the latched address even if the client moved on.
                        tag_d[sel_q]  = lat_addr_q;
                        data_d[sel_q] = word[DW-1:0];
                        if (!inv_seen_q && !INVALIDATE) valid_d[sel_q] = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            last_q     <= IW'(CHANNELS - 1);
            lat_addr_q <= '0;
            ba_addr_q  <= '0;
            ba_rd_q    <= 1'b0;
            cnt_q      <= 2'd0;
            beat0_q    <= 16'h0000;
            beat1_q    <= 16'h0000;
            inv_seen_q <= 1'b0;
            valid_q    <= '0;
            tag_q      <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            lat_addr_q <= lat_addr_d;
            ba_addr_q  <= ba_addr_d;
            ba_rd_q    <= ba_rd_d;
            cnt_q      <= cnt_d;
            beat0_q    <= beat0_d;
            beat1_q    <= beat1_d;
            inv_seen_q <= inv_seen_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: tb/tb_raizing_rom_arbiter.sv
// Directed bench for raizing_rom_arbiter: a round-robin instance with a channel-2 offset
// and a fixed-priority instance, both fed by one hand-driven SDRAM responder.
// Outputs are sampled on the falling clock edge.
module tb_raizing_rom_arbiter;
    localparam int AW  = 22;
    localparam int CAW = 20;
    localparam int DW  = 32;
    localparam logic [4*AW-1:0] OFF_A = {22'h0, 22'h100000, 22'h0, 22'h0};

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    logic          inv_a = 1'b0;
    logic [3:0]    cs_a = '0, cs_b = '0;
    logic [79:0]   addr_a = '0, addr_b = '0;
    logic [3:0]    ok_a, ok_b;
    logic [127:0]  dout_a, dout_b;

    logic          sd_ack = 1'b0, sd_dok = 1'b0, sd_rdy = 1'b0, sel_b = 1'b0;
    logic [15:0]   sd_data = '0;

    raizing_rom_arbiter_if #(.AW(AW)) bus_a ();
    raizing_rom_arbiter_if #(.AW(AW)) bus_b ();

    assign bus_a.BA_ACK    = sd_ack & ~sel_b;
    assign bus_a.BA_DOK    = sd_dok & ~sel_b;
    assign bus_a.BA_RDY    = sd_rdy & ~sel_b;
    assign bus_a.DATA_READ = sd_data;
    assign bus_b.BA_ACK    = sd_ack & sel_b;
    assign bus_b.BA_DOK    = sd_dok & sel_b;
    assign bus_b.BA_RDY    = sd_rdy & sel_b;
    assign bus_b.DATA_READ = sd_data;

    wire          rd_m   = sel_b ? bus_b.BA_RD : bus_a.BA_RD;
    wire [AW-1:0] addr_m = sel_b ? bus_b.BA_ADDR : bus_a.BA_ADDR;

    raizing_rom_arbiter #(.CHANNELS(4), .AW(AW), .CAW(CAW), .DW(DW), .RR(1), .CH_OFFSET(OFF_A)) dut_a (
        .CLK(CLK), .RESET_N(RESET_N), .INVALIDATE(inv_a),
        .CH_CS(cs_a), .CH_ADDR(addr_a), .CH_OK(ok_a), .CH_DOUT(dout_a), .ba(bus_a));

    raizing_rom_arbiter #(.CHANNELS(4), .AW(AW), .CAW(CAW), .DW(DW), .RR(0), .CH_OFFSET('0)) dut_b (
        .CLK(CLK), .RESET_N(RESET_N), .INVALIDATE(1'b0),
        .CH_CS(cs_b), .CH_ADDR(addr_b), .CH_OK(ok_b), .CH_DOUT(dout_b), .ba(bus_b));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Waits (bounded) for BA_RD; returns cycles waited and the requested address.
    task automatic wait_rd(output int lat, output logic [AW-1:0] got);
        lat = 0;
        while (!rd_m && lat < 50) begin
            @(negedge CLK);
            lat++;
        end
        chk("rd_seen", 32'(rd_m), 32'd1);
        got = addr_m;
    endtask

    task automatic ack_pulse();
        sd_ack = 1'b1;
        @(negedge CLK);
        sd_ack = 1'b0;
        chk("rd_drop_after_ack", 32'(rd_m), 32'd0);
    endtask

    // nb beats, BA_RDY on the last; beats past the second carry junk.
    task automatic send_beats(input int nb, input logic [15:0] d0, input logic [15:0] d1);
        for (int b = 0; b < nb; b++) begin
            sd_dok  = 1'b1;
            sd_rdy  = (b == nb - 1);
            sd_data = (b == 0) ? d0 : ((b == 1) ? d1 : 16'hDEAD);
            @(negedge CLK);
        end
        sd_dok = 1'b0;
        sd_rdy = 1'b0;
    endtask

    task automatic serve(input int nb, input logic [15:0] d0, input logic [15:0] d1,
                         output int lat, output logic [AW-1:0] got);
        wait_rd(lat, got);
        ack_pulse();
        send_beats(nb, d0, d1);
    endtask

    task automatic idle_rd(input string nm, input int cycles);
        int seen;
        seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge CLK);
            if (rd_m) seen++;
        end
        chk(nm, 32'(seen), 32'd0);
    endtask

    typedef struct {
        int          ch;
        logic [19:0] addr;
        logic [15:0] d0;
        logic [15:0] d1;
        int          nb;
        logic [21:0] exp_ba;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int lat;
        logic [AW-1:0] got;

        tbl[0] = '{0, 20'h00010, 16'h1234, 16'h5678, 2, 22'h000020,  32'h56781234};
        tbl[1] = '{2, 20'h00005, 16'hAAAA, 16'hBBBB, 2, 22'h10000A,  32'hBBBBAAAA};
        tbl[2] = '{1, 20'h00007, 16'h1111, 16'h2222, 3, 22'h00000E,  32'h22221111};
        tbl[3] = '{3, 20'hFFFFF, 16'h0F0F, 16'h9999, 1, 22'h1FFFFE,  32'h00000F0F};

        // Reset state (all channels requesting address 0, nothing cached yet).
        cs_a = 4'hF;
        repeat (2) @(negedge CLK);
        chk("rst_ba_rd", 32'(bus_a.BA_RD), 32'd0);
        chk("rst_ba_addr", 32'(bus_a.BA_ADDR), 32'd0);
        chk("rst_ok", 32'(ok_a), 32'd0);
        chk("rst_dout", 32'(|dout_a), 32'd0);
        cs_a = 4'h0;
        RESET_N = 1'b1;
        @(negedge CLK);

        // Single-channel misses, then a hit on the same address.
        for (int i = 0; i < 4; i++) begin
            addr_a[tbl[i].ch*CAW +: CAW] = tbl[i].addr;
            cs_a = 4'(1 << tbl[i].ch);
            serve(tbl[i].nb, tbl[i].d0, tbl[i].d1, lat, got);
            chk("tbl_latency", 32'(lat), 32'd1);
            chk("tbl_ba_addr", 32'(got), 32'(tbl[i].exp_ba));
            chk("tbl_dout", dout_a[tbl[i].ch*32 +: 32], tbl[i].exp_dout);
            chk("tbl_ok", 32'(ok_a), 32'(1 << tbl[i].ch));
            idle_rd("tbl_hit_no_rd", 3);
        end

        // DOUT holds with CS dropped; OK follows CS.
        cs_a = 4'h0;
        #1;
        chk("hold_dout", dout_a[31:0], 32'h56781234);
        chk("hold_ok", 32'(ok_a), 32'd0);
        cs_a = 4'h1;
        #1;
        chk("rehit_ok", 32'(ok_a), 32'd1);
        @(negedge CLK);

        // Round robin from reset-derived order: all four miss together.
        for (int c = 0; c < 4; c++) addr_a[c*CAW +: CAW] = 20'h00020 + 20'(c);
        cs_a = 4'hF;
        begin
            logic [21:0] exp_rr [4];
            exp_rr[0] = 22'h000040; exp_rr[1] = 22'h000042;
            exp_rr[2] = 22'h100044; exp_rr[3] = 22'h000046;
            for (int k = 0; k < 4; k++) begin
                serve(2, 16'(k), 16'h0100, lat, got);
                chk("rr_order", 32'(got), 32'(exp_rr[k]));
            end
        end
        chk("rr_all_ok", 32'(ok_a), 32'hF);

        // Channels 0 and 1 keep missing: grants alternate.
        addr_a[0*CAW +: CAW] = 20'h00030;
        addr_a[1*CAW +: CAW] = 20'h00031;
        cs_a = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            serve(2, 16'h3000, 16'h0030, lat, got);
            chk("rr_alternate", 32'(got), 32'h60 + 32'(2 * k));
            addr_a[(k % 2)*CAW +: CAW] = 20'h00032 + 20'(k);
        end
        cs_a = 4'h0;
        @(negedge CLK);

        // Fixed priority instance: channel 0 starves channel 1.
        sel_b = 1'b1;
        addr_b[0*CAW +: CAW] = 20'h00100;
        addr_b[1*CAW +: CAW] = 20'h00200;
        cs_b = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            serve(2, 16'hB000, 16'h000B, lat, got);
            chk("prio_ch0_wins", 32'(got), 32'h200 + 32'(2 * k));
            addr_b[0*CAW +: CAW] = 20'h00101 + 20'(k);
        end
        chk("prio_ch1_starved", 32'(ok_b[1]), 32'd0);
        cs_b = 4'b0010;
        serve(2, 16'hC1C1, 16'h1C1C, lat, got);
        chk("prio_ch1_served", 32'(got), 32'h400);
        chk("prio_ch1_ok", 32'(ok_b), 32'b0010);
        cs_b = 4'h0;
        sel_b = 1'b0;
        @(negedge CLK);

        // Address change after ACK: result cached under the old address, then refetch.
        addr_a[1*CAW +: CAW] = 20'h00040;
        cs_a = 4'b0010;
        wait_rd(lat, got);
        chk("midchg_first", 32'(got), 32'h80);
        ack_pulse();
        addr_a[1*CAW +: CAW] = 20'h00041;
        send_beats(2, 16'h4040, 16'h4141);
        chk("midchg_ok_low", 32'(ok_a[1]), 32'd0);
        chk("midchg_dout", dout_a[63:32], 32'h41414040);
        serve(2, 16'h4242, 16'h4343, lat, got);
        chk("midchg_refetch", 32'(got), 32'h82);
        chk("midchg_ok_high", 32'(ok_a[1]), 32'd1);
        cs_a = 4'h0;
        @(negedge CLK);

        // INVALIDATE raised during DATA.
        addr_a[0*CAW +: CAW] = 20'h00050;
        cs_a = 4'b1101;
        #1;
        chk("inv_pre_ok", 32'(ok_a), 32'b1100);
        wait_rd(lat, got);
        chk("inv_fetch_addr", 32'(got), 32'hA0);
        ack_pulse();
        inv_a = 1'b1;
        send_beats(2, 16'h5050, 16'h0505);
        chk("inv_all_ok_low", 32'(ok_a), 32'd0);
        idle_rd("inv_no_new_rd", 5);
        cs_a = 4'b0001;
        inv_a = 1'b0;
        serve(2, 16'h5151, 16'h1515, lat, got);
        chk("inv_refetch_addr", 32'(got), 32'hA0);
        chk("inv_refetch_ok", 32'(ok_a), 32'b0001);
        chk("inv_refetch_dout", dout_a[31:0], 32'h15155151);

        // Reset while BA_RD is asserted.
        addr_a[0*CAW +: CAW] = 20'h00060;
        wait_rd(lat, got);
        RESET_N = 1'b0;
        #1;
        chk("rst_mid_rd", 32'(bus_a.BA_RD), 32'd0);
        chk("rst_mid_ok", 32'(ok_a), 32'd0);
        chk("rst_mid_dout", 32'(|dout_a), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        serve(2, 16'h6060, 16'h0606, lat, got);
        chk("rst_rerequest", 32'(got), 32'hC0);
        chk("rst_rerequest_ok", 32'(ok_a), 32'b0001);
        cs_a = 4'h0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
